// File: rtl/addmod_arb.sv
// Arbitrated burst accumulator: sums each requester's burst modulo 2^width-1 and returns the result tagged with its owner.
// Define ADDMOD_ARB_FIXED_PRIO_EN for fixed lowest-index priority; otherwise round-robin arbitration is used.
//
// state | meaning
// IDLE  | no owner; first beat of the next burst is accepted from the arbitration winner
// ACC   | owner locked; accumulating further beats until the last one
// OUT   | result presented on res_*; waits for res_ready_i

package lau_pkg;
    typedef enum logic {SLOW, FAST} speed_e;
endpackage

module AddMod2Nm1s0 #(
    parameter int             width = 8,
    parameter lau_pkg::speed_e speed = lau_pkg::FAST
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    output logic [width-1:0] s
);
    logic [width:0]   sum0;
    logic [width-1:0] raw;

    assign sum0 = {1'b0, a} + {1'b0, b};

    // End-around carry; FAST precomputes the +1 path instead of a second ripple add.
    if (speed == lau_pkg::FAST) begin : g_fast
        logic [width-1:0] sum1;
        assign sum1 = a + b + {{(width-1){1'b0}}, 1'b1};
        assign raw  = sum0[width] ? sum1 : sum0[width-1:0];
    end else begin : g_slow
        assign raw = sum0[width-1:0] + {{(width-1){1'b0}}, sum0[width]};
    end

    assign s = (&raw) ? '0 : raw;
endmodule

module addmod_arb #(
    parameter int              width = 8,
    parameter lau_pkg::speed_e speed = lau_pkg::FAST,
    parameter int              nreq  = 4,
    localparam int             idw   = (nreq > 1) ? $clog2(nreq) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [nreq-1:0]       req_valid_i,
    output logic [nreq-1:0]       req_ready_o,
    input  logic [nreq*width-1:0] req_data_i,
    input  logic [nreq-1:0]       req_last_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [width-1:0]      res_data_o,
    output logic [idw-1:0]        res_id_o
);
    typedef enum logic [1:0] {IDLE, ACC, OUT} state_e;

    state_e           state_q, state_d;
    logic [width-1:0] acc_q, sum, add_a, add_b;
    logic [idw-1:0]   owner_q, winner, sel;
    logic [width-1:0] res_data_q;
    logic [idw-1:0]   res_id_q;
    logic             any_valid, sel_valid, sel_last;
    logic             load_first, load_beat, res_hs;

`ifdef ADDMOD_ARB_FIXED_PRIO_EN
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        for (int i = nreq - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                winner    = idw'(i);
                any_valid = 1'b1;
            end
        end
    end
`else
    logic [idw-1:0]  ptr_q;
    logic [nreq-1:0] rot;
    logic [idw:0]    off, wsum;

    // Rotate valids so bit 0 is the requester at the pointer; lowest set bit wins.
    assign rot = nreq'({req_valid_i, req_valid_i} >> ptr_q);

    always_comb begin
        off       = '0;
        any_valid = 1'b0;
        for (int i = nreq - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off       = (idw+1)'(i);
                any_valid = 1'b1;
            end
        end
        wsum   = {1'b0, ptr_q} + off;
        winner = (wsum >= (idw+1)'(nreq)) ? idw'(wsum - (idw+1)'(nreq)) : idw'(wsum);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (res_hs) begin
            ptr_q <= (owner_q == idw'(nreq - 1)) ? '0 : owner_q + 1'b1;
        end
    end
`endif

    assign sel   = (state_q == IDLE) ? winner : owner_q;
    assign add_a = (state_q == IDLE) ? '0 : acc_q;

    always_comb begin
        add_b     = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < nreq; i++) begin
            if (sel == idw'(i)) begin
                add_b     = req_data_i[i*width +: width];
                sel_valid = req_valid_i[i];
                sel_last  = req_last_i[i];
            end
        end
    end

    AddMod2Nm1s0 #(.width(width), .speed(speed)) u_add (
        .a (add_a),
        .b (add_b),
        .s (sum)
    );

    always_comb begin
        state_d     = state_q;
        req_ready_o = '0;
        load_first  = 1'b0;
        load_beat   = 1'b0;
        res_hs      = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    req_ready_o = nreq'(1) << winner;
                    load_first  = 1'b1;
                    state_d     = sel_last ? OUT : ACC;
                end
            end
            ACC: begin
                req_ready_o = nreq'(1) << owner_q;
                if (sel_valid) begin
                    load_beat = 1'b1;
                    if (sel_last) state_d = OUT;
                end
            end
            OUT: begin
                if (res_ready_i) begin
                    res_hs  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst_i) req_ready_o = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            owner_q    <= '0;
            res_data_q <= '0;
            res_id_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load_first || load_beat) acc_q <= sum;
            if (load_first) owner_q <= winner;
            // Result registers only move on entry to OUT so they hold between bursts.
            if (state_d == OUT && state_q != OUT) begin
                res_data_q <= sum;
                res_id_q   <= sel;
            end
        end
    end

    assign res_valid_o = (state_q == OUT);
    assign res_data_o  = res_data_q;
    assign res_id_o    = res_id_q;
endmodule

// File: tb/tb_addmod_arb.sv
// Bench for addmod_arb (width 8, 4 requesters): directed cases plus randomized bursts checked
// every cycle against a transaction-level reference model.
module tb_addmod_arb;
    localparam int W = 8;
    localparam int N = 4;
    localparam int IDW = 2;
    localparam int M = (1 << W) - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_ready, req_last;
    logic [N*W-1:0] req_data;
    logic           res_valid, res_ready;
    logic [W-1:0]   res_data;
    logic [IDW-1:0] res_id;

    always #5 clk = ~clk;

    addmod_arb #(.width(W), .speed(lau_pkg::FAST), .nreq(N)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_data_o  (res_data),
        .res_id_o    (res_id)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Per-requester beat queues; a requester is valid when enabled and holding a beat.
    logic [W-1:0] qd[N][$];
    bit           ql[N][$];
    logic [N-1:0] en;
    int           hs_cnt[N];
    int           obs_id[$];
    int           obs_data[$];

    // Reference model: phase 0 = free, 1 = burst in progress, 2 = result pending.
    int ph, m_owner, m_sum, m_ptr, m_rd, m_rid;

    function automatic int modadd(input int a, input int b);
        return (a + b) % M;
    endfunction

    function automatic int pick(input logic [N-1:0] v);
`ifdef ADDMOD_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (v[i]) return i;
`else
        for (int i = 0; i < N; i++) if (v[(m_ptr + i) % N]) return (m_ptr + i) % N;
`endif
        return -1;
    endfunction

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            req_valid[k]          = en[k] && (qd[k].size() > 0);
            req_data[k*W +: W]    = (qd[k].size() > 0) ? qd[k][0] : '0;
            req_last[k]           = (qd[k].size() > 0) ? ql[k][0] : 1'b0;
        end
    endtask

    task automatic push(input int k, input int d, input bit l);
        qd[k].push_back(W'(d));
        ql[k].push_back(l);
    endtask

    task automatic step();
        logic [N-1:0] exp_rdy;
        int w;
        drive();
        @(negedge clk);
        exp_rdy = '0;
        if (!rst) begin
            if (ph == 0) begin
                w = pick(req_valid);
                if (w >= 0) exp_rdy[w] = 1'b1;
            end else if (ph == 1) begin
                exp_rdy[m_owner] = 1'b1;
            end
        end
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("res_valid", 32'(res_valid), 32'(ph == 2));
        check("res_data", 32'(res_data), 32'(m_rd));
        check("res_id", 32'(res_id), 32'(m_rid));
        if (res_valid && res_ready && !rst) begin
            obs_id.push_back(int'(res_id));
            obs_data.push_back(int'(res_data));
        end
        if (rst) begin
            ph = 0; m_sum = 0; m_ptr = 0; m_rd = 0; m_rid = 0; m_owner = 0;
        end else if (ph == 0) begin
            w = pick(req_valid);
            if (w >= 0) begin
                m_owner = w;
                m_sum = modadd(0, int'(qd[w][0]));
                ph = 1;
                if (ql[w][0]) begin ph = 2; m_rd = m_sum; m_rid = m_owner; end
            end
        end else if (ph == 1) begin
            if (req_valid[m_owner]) begin
                m_sum = modadd(m_sum, int'(qd[m_owner][0]));
                if (ql[m_owner][0]) begin ph = 2; m_rd = m_sum; m_rid = m_owner; end
            end
        end else if (res_ready) begin
            m_ptr = (m_owner + 1) % N;
            ph = 0;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (exp_rdy[k] && req_valid[k]) begin
                void'(qd[k].pop_front());
                void'(ql[k].pop_front());
                hs_cnt[k]++;
            end
        end
    endtask

    task automatic wait_results(input int n, input int budget);
        int start = obs_id.size();
        for (int c = 0; c < budget && obs_id.size() < start + n; c++) step();
        check("result_timeout", 32'(obs_id.size() - start), 32'(n));
    endtask

    task automatic flush();
        for (int k = 0; k < N; k++) begin qd[k].delete(); ql[k].delete(); end
    endtask

    initial begin
        int s, e, b1, lowc, n0, c;
        int burst[4] = '{8'hFE, 8'h01, 8'h80, 8'h90};
        rst = 1'b1; en = '0; res_ready = 1'b1;
        ph = 0; m_owner = 0; m_sum = 0; m_ptr = 0; m_rd = 0; m_rid = 0;
        for (int k = 0; k < N; k++) hs_cnt[k] = 0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        step();
        rst = 1'b0;

        // single beat from requester 0
        push(0, 8'h12, 1'b1);
        en = 4'b0001;
        step();
        check("r030_valid_next", 32'(res_valid), 32'd1);
        check("r030_data_next", 32'(res_data), 32'h12);
        wait_results(1, 10);
        check("r030_id", 32'(obs_id[$]), 32'd0);
        check("r030_data", 32'(obs_data[$]), 32'h12);

        // modular wrap burst from requester 2
        e = 0;
        for (int i = 0; i < 4; i++) begin
            push(2, burst[i], i == 3);
            e = modadd(e, burst[i]);
        end
        en = 4'b0100;
        wait_results(1, 20);
        check("r031_id", 32'(obs_id[$]), 32'd2);
        check("r031_data", 32'(obs_data[$]), 32'(e));

        // result held while res_ready is low
        res_ready = 1'b0;
        push(3, 8'h5A, 1'b1);
        en = 4'b1000;
        c = 0;
        while (!res_valid && c < 10) begin step(); c++; end
        check("r033_reach_out", 32'(res_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("r033_hold_valid", 32'(res_valid), 32'd1);
            check("r033_hold_data", 32'(res_data), 32'h5A);
            check("r033_hold_id", 32'(res_id), 32'd3);
            check("r033_no_ready", 32'(req_ready), 32'd0);
        end
        res_ready = 1'b1;
        wait_results(1, 5);

        // reset in the middle of a burst, then continuous valid on all requesters
        for (int i = 0; i < 4; i++) push(2, 8'h11 * (i + 1), i == 3);
        en = 4'b0100;
        b1 = hs_cnt[2];
        c = 0;
        while (hs_cnt[2] < b1 + 2 && c < 10) begin step(); c++; end
        check("r035_two_beats", 32'(hs_cnt[2] - b1), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        flush();
        n0 = obs_id.size();
        check("r035_valid0", 32'(res_valid), 32'd0);
        check("r035_data0", 32'(res_data), 32'd0);
        check("r035_id0", 32'(res_id), 32'd0);
        for (int k = 0; k < N; k++) for (int i = 0; i < 8; i++) push(k, k + 1, 1'b1);
        en = 4'hF;
        wait_results(5, 40);
        for (int i = 0; i < 5; i++) begin
`ifdef ADDMOD_ARB_FIXED_PRIO_EN
            check("r032_id", 32'(obs_id[n0 + i]), 32'd0);
`else
            check("r032_id", 32'(obs_id[n0 + i]), 32'(i % N));
`endif
            check("r032_data", 32'(obs_data[n0 + i]), 32'(obs_id[n0 + i] + 1));
        end
        en = '0;
        c = 0;
        while (ph != 0 && c < 10) begin step(); c++; end
        flush();

        // grant stays locked on requester 1 while it stalls
        push(1, 8'h01, 1'b0); push(1, 8'h02, 1'b0); push(1, 8'h03, 1'b1);
        push(3, 8'h44, 1'b1);
        en = 4'b1010;
        s = obs_id.size();
        b1 = hs_cnt[1];
        lowc = 0;
        c = 0;
        while (obs_id.size() < s + 2 && c < 40) begin
            en[1] = !((hs_cnt[1] - b1 == 1) && lowc < 2);
            if (!en[1]) lowc++;
            step();
            c++;
        end
        check("r034_count", 32'(obs_id.size() - s), 32'd2);
        check("r034_first_id", 32'(obs_id[s]), 32'd1);
        check("r034_first_data", 32'(obs_data[s]), 32'h06);
        check("r034_second_id", 32'(obs_id[s + 1]), 32'd3);
        check("r034_second_data", 32'(obs_data[s + 1]), 32'h44);
        flush();

        // randomized bursts, back-pressure and occasional resets
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int k = 0; k < N; k++) begin
                if (qd[k].size() == 0 && $urandom_range(2) == 0) begin
                    int len = $urandom_range(4, 1);
                    for (int i = 0; i < len; i++) begin
                        int r = $urandom_range(7);
                        push(k, (r == 0) ? 8'hFF : (r == 1) ? 8'hFE : int'($urandom_range(255)), i == len - 1);
                    end
                end
            end
            en = N'($urandom);
            res_ready = ($urandom_range(3) != 0);
            rst = ($urandom_range(299) == 0);
            step();
        end
        rst = 1'b0; en = 4'hF; res_ready = 1'b1;
        c = 0;
        while ((ph != 0 || qd[0].size() + qd[1].size() + qd[2].size() + qd[3].size() > 0) && c < 500) begin
            step();
            c++;
        end
        check("drain_idle", 32'(ph), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
